// File: rtl/xor_checksum_checker.sv
// xor_checksum_checker: checks a block of N data words against a trailing XOR checksum word, per byte lane
module xor_checksum_checker #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [WIDTH/8-1:0] lane_err,
  output logic [WIDTH-1:0]   acc,
  output logic [LEN_W-1:0]   word_cnt
);
  localparam int LANES = WIDTH / 8;
  typedef enum logic [1:0] {IDLE, DATA, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_nx;
  logic [WIDTH-1:0] diff;
  logic [LANES-1:0] lane_nx;
  logic accept;
  assign in_ready = state == DATA || state == CHECK;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign accept   = in_valid & in_ready;
  assign diff     = acc ^ in_data;
  assign cnt_nx   = word_cnt + LEN_W'(1);
  always_comb begin
    lane_nx = '0;
    for (int i = 0; i < LANES; i++) lane_nx[i] = |diff[8*i +: 8];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (len == '0) ? CHECK : DATA;
      DATA:  if (accept && cnt_nx == len_q) state_nx = CHECK;
      CHECK: if (accept) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      acc      <= '0;
      word_cnt <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      lane_err <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        len_q    <= len;
        acc      <= '0;
        word_cnt <= '0;
        pass     <= 1'b0;
        fail     <= 1'b0;
        lane_err <= '0;
      end
      if (state == DATA && accept) begin
        acc      <= diff;
        word_cnt <= cnt_nx;
      end
      if (state == CHECK && accept) begin
        lane_err <= lane_nx;
        pass     <= ~|lane_nx;
        fail     <= |lane_nx;
      end
    end
  end
endmodule

// File: tb/tb_xor_checksum_checker.sv
// tb_xor_checksum_checker: directed self-checking bench for xor_checksum_checker
module tb_xor_checksum_checker;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0]  len = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, busy, done, pass, fail;
  logic [3:0]  lane_err;
  logic [31:0] acc;
  logic [7:0]  word_cnt;
  int checks = 0, errors = 0;
  logic [31:0] w [8];

  xor_checksum_checker #(.WIDTH(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .lane_err(lane_err), .acc(acc), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [31:0] csum, output int cyc, output logic rdy1);
    start = 1; len = n[7:0]; tick; start = 0; cyc = 1;
    rdy1 = in_ready & busy;
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_data = w[i]; tick; cyc++;
    end
    in_valid = 1; in_data = csum; tick; cyc++;
    in_valid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); in_valid = 1'($urandom); len = 8'($urandom); in_data = $urandom;
      tick;
    end
    checks++; if ({in_ready, busy, done, pass, fail} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {in_ready, busy, done, pass, fail}); end
    checks++; if (lane_err !== 4'h0) begin errors++; $display("FAIL reset_lane_err got %b want 0000", lane_err); end
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL reset_acc got %h want 00000000", acc); end
    checks++; if (word_cnt !== 8'h0) begin errors++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt); end
    start = 0; in_valid = 0; len = 0; in_data = 0;
    rst_n = 1; tick;
  endtask

  task automatic test_good;
    int cyc; logic rdy1;
    w[0] = 32'h11223344; w[1] = 32'hA5A5A5A5; w[2] = 32'h0F0F0F0F;
    send(3, 32'hBB8899EE, cyc, rdy1);
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL good_ready_after_start got %b want 1", rdy1); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done got %b want 1", done); end
    checks++; if ({pass, fail} !== 2'b10) begin errors++; $display("FAIL good_pass_fail got %b want 10", {pass, fail}); end
    checks++; if (lane_err !== 4'h0) begin errors++; $display("FAIL good_lane_err got %b want 0000", lane_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL good_done_ready got %b want 0", in_ready); end
    tick; cyc++;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL good_idle got %b want 00", {busy, done}); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL good_period got %0d want 6", cyc); end
    checks++; if ({pass, fail} !== 2'b10) begin errors++; $display("FAIL good_pass_held got %b want 10", {pass, fail}); end
  endtask

  task automatic test_corrupt;
    int cyc; logic rdy1;
    w[0] = 32'h11223344; w[1] = 32'hA5A5A5A5; w[2] = 32'h0F0F0F0F;
    send(3, 32'hBB889900, cyc, rdy1);
    checks++; if ({done, pass, fail} !== 3'b101) begin errors++; $display("FAIL corrupt_done_pass_fail got %b want 101", {done, pass, fail}); end
    checks++; if (lane_err !== 4'b0001) begin errors++; $display("FAIL corrupt_lane_err got %b want 0001", lane_err); end
    checks++; if (acc !== 32'hBB8899EE) begin errors++; $display("FAIL corrupt_acc got %h want bb8899ee", acc); end
    tick;
  endtask

  task automatic test_zero_len;
    int cyc; logic rdy1;
    send(0, 32'h0, cyc, rdy1);
    checks++; if ({done, pass, fail} !== 3'b110) begin errors++; $display("FAIL zero_pass got %b want 110", {done, pass, fail}); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL zero_cycles got %0d want 2", cyc); end
    tick;
    send(0, 32'h80000001, cyc, rdy1);
    checks++; if ({done, pass, fail} !== 3'b101) begin errors++; $display("FAIL zero_fail got %b want 101", {done, pass, fail}); end
    checks++; if (lane_err !== 4'b1001) begin errors++; $display("FAIL zero_lane_err got %b want 1001", lane_err); end
    tick;
  endtask

  task automatic test_gaps;
    int i = 0, guard = 0;
    logic v, mid = 0;
    w[0] = 32'h01020304; w[1] = 32'h10203040; w[2] = 32'hAABBCCDD; w[3] = 32'h0F0F0F0F;
    start = 1; len = 4; tick; start = 0;
    while (i < 4 && guard < 40) begin
      v = (guard % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == 2 && !mid) begin start = 1; len = 1; mid = 1; end
      in_valid = v; in_data = v ? w[i] : 32'hDEADBEEF;
      tick; start = 0; guard++;
      if (v) i++;
      checks++; if (word_cnt !== 8'(i)) begin errors++; $display("FAIL gaps_word_cnt got %0d want %0d", word_cnt, i); end
    end
    in_valid = 0; tick;
    checks++; if ({in_ready, busy, done} !== 3'b110) begin errors++; $display("FAIL gaps_check_hold got %b want 110", {in_ready, busy, done}); end
    in_valid = 1; in_data = 32'hB496F096; tick; in_valid = 0;
    checks++; if ({done, pass, fail} !== 3'b110) begin errors++; $display("FAIL gaps_result got %b want 110", {done, pass, fail}); end
    checks++; if (acc !== 32'hB496F096) begin errors++; $display("FAIL gaps_acc got %h want b496f096", acc); end
    tick;
  endtask

  task automatic test_reset_mid;
    int cyc; logic rdy1;
    start = 1; len = 5; tick; start = 0;
    in_valid = 1; in_data = 32'h12345678; tick;
    in_data = 32'h9ABCDEF0; tick;
    in_valid = 0; rst_n = 0; tick; rst_n = 1;
    checks++; if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL mid_reset_idle got %b want 00", {in_ready, busy}); end
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL mid_reset_acc got %h want 00000000", acc); end
    checks++; if (word_cnt !== 8'h0) begin errors++; $display("FAIL mid_reset_word_cnt got %0d want 0", word_cnt); end
    w[0] = 32'h11223344; w[1] = 32'hA5A5A5A5; w[2] = 32'h0F0F0F0F;
    send(3, 32'hBB8899EE, cyc, rdy1);
    checks++; if ({done, pass, fail} !== 3'b110) begin errors++; $display("FAIL mid_reset_fresh got %b want 110", {done, pass, fail}); end
    tick;
  endtask

  initial begin
    test_reset;
    test_good;
    test_corrupt;
    test_zero_len;
    test_gaps;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
